// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decoder with valid/ready handshake, 2-entry skid FIFO and flush
// Ports: clk/rst (sync active-high), flush; in_valid/in_ready/in_instr/in_pc from fetch;
// out_valid/out_ready handshake; decoded head entry on out_pc, sel_a (MSB selects PC), sel_b, sel_out,
// alu_ctrl {funct7,funct3}, imm, use_imm, funct3 and control flags reg_we/mem_re/mem_we/branch/jump/illegal.
module decode_stage #(
  parameter int XLEN = 32,
  parameter int REG_AW = 5,
  parameter int PC_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [PC_W-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [REG_AW:0]   sel_a,
  output logic [REG_AW-1:0] sel_b,
  output logic [REG_AW-1:0] sel_out,
  output logic [9:0]        alu_ctrl,
  output logic [XLEN-1:0]   imm,
  output logic              use_imm,
  output logic [2:0]        funct3,
  output logic              reg_we,
  output logic              mem_re,
  output logic              mem_we,
  output logic              branch,
  output logic              jump,
  output logic              illegal
);
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [REG_AW:0]   sa;
    logic [REG_AW-1:0] sb;
    logic [REG_AW-1:0] so;
    logic [9:0]        alu;
    logic [XLEN-1:0]   imm;
    logic              ui;
    logic [2:0]        f3;
    logic              rwe, mre, mwe, br, jp, ill;
  } ent_t;
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [REG_AW:0] rs1;
  logic [REG_AW-1:0] rs2, rd;
  logic [XLEN-1:0] i_imm, s_imm, b_imm, u_imm, j_imm;
  logic sh;
  ent_t d, e0, e1;
  logic [1:0] cnt;
  logic push, pop;
  assign opc = in_instr[6:0];
  assign f3 = in_instr[14:12];
  assign f7 = in_instr[31:25];
  assign rd = REG_AW'(in_instr[11:7]);
  assign rs1 = (REG_AW+1)'(in_instr[19:15]);
  assign rs2 = REG_AW'(in_instr[24:20]);
  assign i_imm = {{(XLEN-11){in_instr[31]}}, in_instr[30:20]};
  assign s_imm = {{(XLEN-11){in_instr[31]}}, in_instr[30:25], in_instr[11:7]};
  assign b_imm = {{(XLEN-12){in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign u_imm = {{(XLEN-31){in_instr[31]}}, in_instr[30:12], 12'b0};
  assign j_imm = {{(XLEN-20){in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
  // OP-IMM shifts carry shamt in the immediate field and funct7 selects logical/arithmetic
  assign sh = f3[1:0] == 2'b01;
  always_comb begin
    d = '0;
    d.pc = in_pc;
    d.f3 = f3;
    case (opc)
      7'b0110011: begin d.sa = rs1; d.sb = rs2; d.so = rd; d.alu = {f7, f3}; d.rwe = 1'b1; end
      7'b0010011: begin
        d.sa = rs1; d.so = rd; d.ui = 1'b1; d.rwe = 1'b1;
        d.imm = sh ? XLEN'(in_instr[24:20]) : i_imm;
        d.alu = sh ? {f7, f3} : {7'b0, f3};
      end
      7'b0000011: begin d.sa = rs1; d.so = rd; d.imm = i_imm; d.ui = 1'b1; d.mre = 1'b1; d.rwe = 1'b1; end
      7'b0100011: begin d.sa = rs1; d.sb = rs2; d.imm = s_imm; d.ui = 1'b1; d.mwe = 1'b1; end
      7'b1100011: begin d.sa = rs1; d.sb = rs2; d.imm = b_imm; d.alu = 10'h100; d.br = 1'b1; end
      7'b0110111: begin d.so = rd; d.imm = u_imm; d.ui = 1'b1; d.rwe = 1'b1; end
      7'b0010111: begin d.sa = {1'b1, {REG_AW{1'b0}}}; d.so = rd; d.imm = u_imm; d.ui = 1'b1; d.rwe = 1'b1; end
      7'b1101111: begin d.sa = {1'b1, {REG_AW{1'b0}}}; d.so = rd; d.imm = j_imm; d.jp = 1'b1; d.rwe = 1'b1; end
      7'b1100111: begin
        if (f3 == 3'b000) begin
          d.sa = rs1; d.so = rd; d.imm = i_imm; d.ui = 1'b1; d.jp = 1'b1; d.rwe = 1'b1;
        end else d.ill = 1'b1;
      end
      default: d.ill = 1'b1;
    endcase
    d.rwe = d.rwe & (rd != '0);
  end
  assign in_ready = cnt != 2'd2;
  assign out_valid = cnt != 2'd0;
  assign push = in_valid & in_ready;
  assign pop = out_valid & out_ready;
  // e0 is always the head; a pop shifts e1 forward or takes the incoming entry directly
  always_ff @(posedge clk) begin
    if (rst | flush) begin
      cnt <= '0;
      e0 <= '0;
      e1 <= '0;
    end else begin
      if (pop) e0 <= cnt[1] ? e1 : d;
      else if (push && cnt == 2'd0) e0 <= d;
      if (push && cnt == 2'd1 && !pop) e1 <= d;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end
  assign out_pc = e0.pc;
  assign sel_a = e0.sa;
  assign sel_b = e0.sb;
  assign sel_out = e0.so;
  assign alu_ctrl = e0.alu;
  assign imm = e0.imm;
  assign use_imm = e0.ui;
  assign funct3 = e0.f3;
  assign reg_we = e0.rwe;
  assign mem_re = e0.mre;
  assign mem_we = e0.mwe;
  assign branch = e0.br;
  assign jump = e0.jp;
  assign illegal = e0.ill;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: table-driven decode vectors plus backpressure, ordering and flush sequences
module tb_decode_stage;
  logic clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 1;
  logic [31:0] in_instr = 0, in_pc = 0;
  logic in_ready, out_valid, use_imm, reg_we, mem_re, mem_we, branch, jump, illegal;
  logic [31:0] out_pc, imm;
  logic [5:0] sel_a;
  logic [4:0] sel_b, sel_out;
  logic [9:0] alu_ctrl;
  logic [2:0] funct3;
  int errors = 0, checks = 0;
  decode_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .sel_a(sel_a), .sel_b(sel_b), .sel_out(sel_out), .alu_ctrl(alu_ctrl),
    .imm(imm), .use_imm(use_imm), .funct3(funct3), .reg_we(reg_we), .mem_re(mem_re),
    .mem_we(mem_we), .branch(branch), .jump(jump), .illegal(illegal)
  );
  always #5 clk = ~clk;
  typedef struct {
    string nm;
    logic [31:0] instr;
    logic full;
    logic [5:0] sa;
    logic [4:0] sb, so;
    logic [9:0] alu;
    logic [31:0] imm;
    logic ui;
    logic [2:0] f3;
    logic [5:0] fl;
  } vec_t;
  vec_t v[14];
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic push_one(logic [31:0] ins, logic [31:0] pc);
    @(negedge clk);
    in_valid = 1; in_instr = ins; in_pc = pc;
    @(negedge clk);
    in_valid = 0;
  endtask
  function automatic logic [5:0] flags();
    return {reg_we, mem_re, mem_we, branch, jump, illegal};
  endfunction
  initial begin
    // flags = {reg_we, mem_re, mem_we, branch, jump, illegal}
    v[0]  = '{"add",      32'h002081B3, 1, 6'h01, 5'd2, 5'd3, 10'h000, 32'h0,        0, 3'd0, 6'b100000};
    v[1]  = '{"sw",       32'hFE512E23, 1, 6'h02, 5'd5, 5'd0, 10'h000, 32'hFFFFFFFC, 1, 3'd2, 6'b001000};
    v[2]  = '{"beq",      32'hFE208CE3, 1, 6'h01, 5'd2, 5'd0, 10'h100, 32'hFFFFFFF8, 0, 3'd0, 6'b000100};
    v[3]  = '{"srai",     32'h40325213, 1, 6'h04, 5'd0, 5'd4, 10'h105, 32'h3,        1, 3'd5, 6'b100000};
    v[4]  = '{"zero",     32'h00000000, 0, 6'h00, 5'd0, 5'd0, 10'h000, 32'h0,        0, 3'd0, 6'b000001};
    v[5]  = '{"jalr_f3",  32'h000010E7, 0, 6'h00, 5'd0, 5'd0, 10'h000, 32'h0,        0, 3'd1, 6'b000001};
    v[6]  = '{"nop",      32'h00000013, 1, 6'h00, 5'd0, 5'd0, 10'h000, 32'h0,        1, 3'd0, 6'b000000};
    v[7]  = '{"lui",      32'h123450B7, 1, 6'h00, 5'd0, 5'd1, 10'h000, 32'h12345000, 1, 3'd5, 6'b100000};
    v[8]  = '{"auipc",    32'hFFFFF117, 1, 6'h20, 5'd0, 5'd2, 10'h000, 32'hFFFFF000, 1, 3'd7, 6'b100000};
    v[9]  = '{"jal",      32'h008000EF, 1, 6'h20, 5'd0, 5'd1, 10'h000, 32'h8,        0, 3'd0, 6'b100010};
    v[10] = '{"jalr",     32'h000080E7, 1, 6'h01, 5'd0, 5'd1, 10'h000, 32'h0,        1, 3'd0, 6'b100010};
    v[11] = '{"lw",       32'hFFC12183, 1, 6'h02, 5'd0, 5'd3, 10'h000, 32'hFFFFFFFC, 1, 3'd2, 6'b110000};
    v[12] = '{"sub",      32'h407302B3, 1, 6'h06, 5'd7, 5'd5, 10'h100, 32'h0,        0, 3'd0, 6'b100000};
    v[13] = '{"andi",     32'hFFF17093, 1, 6'h02, 5'd0, 5'd1, 10'h007, 32'hFFFFFFFF, 1, 3'd7, 6'b100000};
    repeat (2) @(negedge clk);
    rst = 0;
    chk("rst out_valid", 64'(out_valid), 0);
    chk("rst in_ready", 64'(in_ready), 1);
    chk("rst data", {out_pc, imm}, 0);
    chk("rst ctrl", {sel_a, sel_b, sel_out, alu_ctrl, use_imm, funct3, flags()}, 0);
    for (int i = 0; i < 14; i++) begin
      push_one(v[i].instr, 32'h1000 + 32'(i) * 4);
      chk({v[i].nm, " out_valid"}, 64'(out_valid), 1);
      chk({v[i].nm, " flags"}, 64'(flags()), 64'(v[i].fl));
      chk({v[i].nm, " funct3"}, 64'(funct3), 64'(v[i].f3));
      chk({v[i].nm, " out_pc"}, 64'(out_pc), 64'(32'h1000 + 32'(i) * 4));
      if (v[i].full) begin
        chk({v[i].nm, " sel_a"}, 64'(sel_a), 64'(v[i].sa));
        chk({v[i].nm, " sel_b"}, 64'(sel_b), 64'(v[i].sb));
        chk({v[i].nm, " sel_out"}, 64'(sel_out), 64'(v[i].so));
        chk({v[i].nm, " alu_ctrl"}, 64'(alu_ctrl), 64'(v[i].alu));
        chk({v[i].nm, " imm"}, 64'(imm), 64'(v[i].imm));
        chk({v[i].nm, " use_imm"}, 64'(use_imm), 64'(v[i].ui));
      end
    end
    @(negedge clk);
    chk("drained", 64'(out_valid), 0);
    // backpressure: A and B fill the buffer, C is held until a slot frees
    out_ready = 0;
    in_valid = 1; in_instr = v[0].instr; in_pc = 32'hA0;
    @(negedge clk);
    in_instr = v[1].instr; in_pc = 32'hB0;
    @(negedge clk);
    in_instr = v[3].instr; in_pc = 32'hC0;
    chk("full in_ready", 64'(in_ready), 0);
    chk("full head A", 64'(out_pc), 64'h0A0);
    @(negedge clk);
    chk("stall in_ready", 64'(in_ready), 0);
    chk("stall head A", {out_pc, 16'(sel_out)}, {32'hA0, 16'd3});
    out_ready = 1;
    @(negedge clk);
    chk("pop1 head B", 64'(out_pc), 64'h0B0);
    chk("pop1 in_ready", 64'(in_ready), 1);
    @(negedge clk);
    in_valid = 0;
    chk("pop2 head C", 64'(out_pc), 64'h0C0);
    chk("pop2 C alu", 64'(alu_ctrl), 64'h105);
    chk("pop2 valid", 64'(out_valid), 1);
    @(negedge clk);
    chk("pop3 empty", 64'(out_valid), 0);
    // flush with a full buffer and a new instruction presented
    out_ready = 0;
    push_one(v[0].instr, 32'hD0);
    push_one(v[1].instr, 32'hD4);
    chk("pre-flush full", 64'(in_ready), 0);
    @(negedge clk);
    flush = 1; in_valid = 1; in_instr = v[2].instr; in_pc = 32'hD8;
    @(negedge clk);
    flush = 0; in_valid = 0; out_ready = 1;
    chk("flush out_valid", 64'(out_valid), 0);
    chk("flush in_ready", 64'(in_ready), 1);
    repeat (2) begin
      @(negedge clk);
      chk("flush dropped", 64'(out_valid), 0);
    end
    // flush with an empty buffer drops the presented instruction too
    flush = 1; in_valid = 1; in_instr = v[0].instr; in_pc = 32'hE0;
    @(negedge clk);
    flush = 0; in_valid = 0;
    chk("flush empty drop", 64'(out_valid), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
